pixel_writeback_responder: RTL and testbench

//  Responder end of the IPU pixel-write handshake: takes one 8-bit filtered pixel per request at (h,v).

---
 rtl/pixel_writeback_responder_pkg.sv | 19 +
 rtl/pixel_writeback_responder_lane_merge.sv | 32 +++
 rtl/pixel_writeback_responder.sv | 146 ++++++++++++++
 tb/tb_pixel_writeback_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_writeback_responder_pkg.sv
// Shared types and defaults for the IPU pixel write-back responder.
// Optional read-modify-write merge is enabled with RMW_MERGE_EN.
package pixel_writeback_responder_pkg;

  localparam int DEF_H_BITS     = 9;
  localparam int DEF_V_BITS     = 9;
  localparam int DEF_PIX_W      = 8;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_RD_LATENCY = 1;
  localparam int LANES          = 4;
  localparam int LANE_W         = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WRITE   = 2'd2
  } state_e;

endpackage

// File: rtl/pixel_writeback_responder_lane_merge.sv
// Combinational 4-lane merge: incoming pixel into its lane,
// RAM read data into lanes not yet written.
module pixel_writeback_responder_lane_merge
  import pixel_writeback_responder_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic [LANES*PIX_W-1:0] buf_i,
  input  logic [LANES-1:0]       mask_i,
  input  logic [PIX_W-1:0]       pix_i,
  input  logic [LANE_W-1:0]      lane_i,
  input  logic                   pix_en_i,
  input  logic [LANES*PIX_W-1:0] rdata_i,
  input  logic                   fill_i,
  output logic [LANES*PIX_W-1:0] buf_o,
  output logic [LANES-1:0]       mask_o
);

  always_comb begin
    buf_o  = buf_i;
    mask_o = mask_i;
    for (int k = 0; k < LANES; k++) begin
      if (fill_i && !mask_i[k])
        buf_o[k*PIX_W +: PIX_W] = rdata_i[k*PIX_W +: PIX_W];
      if (pix_en_i && (lane_i == LANE_W'(k))) begin
        buf_o[k*PIX_W +: PIX_W] = pix_i;
        mask_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_writeback_responder.sv
// Packs IPU pixels four per word and writes them to the frame RAM.
// Define RMW_MERGE_EN to read back and merge partially filled words.
module pixel_writeback_responder
  import pixel_writeback_responder_pkg::*;
#(
  parameter int H_BITS     = DEF_H_BITS,
  parameter int V_BITS     = DEF_V_BITS,
  parameter int PIX_W      = DEF_PIX_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_req,
  input  logic [PIX_W-1:0]       pixel,
  input  logic [H_BITS-1:0]      pix_h,
  input  logic [V_BITS-1:0]      pix_v,
  input  logic                   flush,
  output logic                   wr_done,
  output logic                   busy,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [LANES*PIX_W-1:0] mem_wdata,
  output logic                   mem_we,
  output logic                   mem_rd,
  input  logic [LANES*PIX_W-1:0] mem_rdata
);

  localparam int WORD_W = LANES * PIX_W;
  localparam int CNT_W  = $clog2(RD_LATENCY + 2);
  localparam logic [CNT_W-1:0]  RD_LAST = CNT_W'(RD_LATENCY);
  localparam logic [LANES-1:0]  FULL    = {LANES{1'b1}};

  state_e              state_q, state_d, flush_tgt;
  logic [WORD_W-1:0]   buf_q, buf_d, m_buf;
  logic [LANES-1:0]    mask_q, mask_d, m_mask;
  logic                valid_q, valid_d;
  logic                pend_q, pend_d, pend_any;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d, req_addr;
  logic                ack_q, ack_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                accept, same_word, take, fill;

  assign req_addr  = {pix_v, pix_h[H_BITS-1:2]};
  assign accept    = (state_q == IDLE) && wr_req && !ack_q;
  assign same_word = !valid_q || (req_addr == cur_addr_q);
  assign take      = accept && same_word;
  assign fill      = (state_q == RD_WAIT) && (cnt_q == RD_LAST);
  assign pend_any  = flush || pend_q;

`ifdef RMW_MERGE_EN
  assign flush_tgt = (mask_q == FULL) ? WRITE : RD_WAIT;
  assign mem_rd    = (state_q == RD_WAIT) && (cnt_q != RD_LAST);
`else
  assign flush_tgt = WRITE;
  assign mem_rd    = 1'b0;
`endif

  pixel_writeback_responder_lane_merge #(
    .PIX_W (PIX_W)
  ) u_lane_merge (
    .buf_i    (buf_q),
    .mask_i   (mask_q),
    .pix_i    (pixel),
    .lane_i   (pix_h[1:0]),
    .pix_en_i (take),
    .rdata_i  (mem_rdata),
    .fill_i   (fill),
    .buf_o    (m_buf),
    .mask_o   (m_mask)
  );

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    mask_d     = mask_q;
    valid_d    = valid_q;
    pend_d     = pend_q;
    cur_addr_d = cur_addr_q;
    cnt_d      = cnt_q;
    ack_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          buf_d      = m_buf;
          mask_d     = m_mask;
          valid_d    = 1'b1;
          cur_addr_d = req_addr;
          pend_d     = pend_any;
          ack_d      = 1'b1;
        end else begin
          // full word, pending flush, or a different-word request evicts
          pend_d = pend_any && valid_q;
          if (valid_q && (pend_any || (mask_q == FULL) || accept)) begin
            state_d = flush_tgt;
            cnt_d   = '0;
          end
        end
      end
      RD_WAIT: begin
        if (fill) begin
          buf_d   = m_buf;
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE: begin
        buf_d   = '0;
        mask_d  = '0;
        valid_d = 1'b0;
        pend_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      mask_q     <= '0;
      valid_q    <= 1'b0;
      pend_q     <= 1'b0;
      cur_addr_q <= '0;
      ack_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      mask_q     <= mask_d;
      valid_q    <= valid_d;
      pend_q     <= pend_d;
      cur_addr_q <= cur_addr_d;
      ack_q      <= ack_d;
      cnt_q      <= cnt_d;
    end
  end

  assign wr_done   = ack_q;
  assign busy      = (state_q != IDLE);
  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = (state_q != IDLE) ? cur_addr_q : '0;
  assign mem_wdata = (state_q == WRITE) ? buf_q : '0;

endmodule

// File: tb/tb_pixel_writeback_responder.sv
// Directed vector bench for pixel_writeback_responder.
// Covers both builds; RMW_MERGE_EN selects the merge expectations.
module tb_pixel_writeback_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_req = 1'b0;
  logic [7:0]  pixel = '0;
  logic [8:0]  pix_h = '0;
  logic [8:0]  pix_v = '0;
  logic        flush = 1'b0;
  logic        wr_done, busy, mem_we, mem_rd;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] ram [0:65535];

  int n_pass = 0;
  int n_total = 0;
  int b2b = 0;
  logic we_prev = 1'b0;

  always #5 clk = ~clk;

  pixel_writeback_responder dut (
    .clk       (clk),
    .reset     (reset),
    .wr_req    (wr_req),
    .pixel     (pixel),
    .pix_h     (pix_h),
    .pix_v     (pix_v),
    .flush     (flush),
    .wr_done   (wr_done),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_we && we_prev) b2b++;
    we_prev <= mem_we;
  end

  typedef struct {
    bit          r;
    bit          q;
    logic [7:0]  px;
    logic [8:0]  h;
    logic [8:0]  v;
    bit          f;
    bit          e_done;
    bit          e_we;
    bit          e_busy;
    bit          e_rd;
    logic [15:0] e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit q, input logic [7:0] px,
                     input int h, input int v, input bit f,
                     input bit d, input bit we, input bit bz, input bit rd,
                     input logic [15:0] a, input logic [31:0] dat);
    vec_t t;
    t.r = r; t.q = q; t.px = px; t.h = 9'(h); t.v = 9'(v); t.f = f;
    t.e_done = d; t.e_we = we; t.e_busy = bz; t.e_rd = rd;
    t.e_addr = a; t.e_data = dat;
    vecs.push_back(t);
  endtask

  task automatic nop(input bit d, input bit we, input bit bz,
                     input logic [15:0] a, input logic [31:0] dat);
    add(0, 0, 8'h00, 0, 0, 0, d, we, bz, 1'b0, a, dat);
  endtask

  task automatic check(input string name, input bit ok,
                       input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  initial begin
    logic [3:0]  g_flags, e_flags;
    bit          ok;
    int          n, wes;
    logic [15:0] w_addr;
    logic [31:0] w_data;

    for (int i = 0; i < 65536; i++) ram[i] = '0;
    ram[16'h0081] = 32'hDEADBEEF;

    // reset state
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 16'h0, 32'h0);
    // four lanes of one word
    add(0, 1, 8'hA0, 0, 0, 0, 1, 0, 0, 0, 16'h0, 32'h0);
    nop(0, 0, 0, 16'h0, 32'h0);
    add(0, 1, 8'hA1, 1, 0, 0, 1, 0, 0, 0, 16'h0, 32'h0);
    nop(0, 0, 0, 16'h0, 32'h0);
    add(0, 1, 8'hA2, 2, 0, 0, 1, 0, 0, 0, 16'h0, 32'h0);
    nop(0, 0, 0, 16'h0, 32'h0);
    add(0, 1, 8'hA3, 3, 0, 0, 1, 0, 0, 0, 16'h0, 32'h0);
    nop(0, 1, 1, 16'h0000, 32'hA3A2A1A0);
    nop(0, 0, 0, 16'h0, 32'h0);
    // reset with three lanes buffered, then flush on empty buffer
    add(0, 1, 8'h44, 0, 3, 0, 1, 0, 0, 0, 16'h0, 32'h0);
    nop(0, 0, 0, 16'h0, 32'h0);
    add(0, 1, 8'h45, 1, 3, 0, 1, 0, 0, 0, 16'h0, 32'h0);
    nop(0, 0, 0, 16'h0, 32'h0);
    add(0, 1, 8'h46, 2, 3, 0, 1, 0, 0, 0, 16'h0, 32'h0);
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 16'h0, 32'h0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 16'h0, 32'h0);
    nop(0, 0, 0, 16'h0, 32'h0);
    nop(0, 0, 0, 16'h0, 32'h0);
    // flush together with the 4th same-word lane
    add(0, 1, 8'h60, 12, 4, 0, 1, 0, 0, 0, 16'h0, 32'h0);
    nop(0, 0, 0, 16'h0, 32'h0);
    add(0, 1, 8'h61, 13, 4, 0, 1, 0, 0, 0, 16'h0, 32'h0);
    nop(0, 0, 0, 16'h0, 32'h0);
    add(0, 1, 8'h62, 14, 4, 0, 1, 0, 0, 0, 16'h0, 32'h0);
    nop(0, 0, 0, 16'h0, 32'h0);
    add(0, 1, 8'h63, 15, 4, 1, 1, 0, 0, 0, 16'h0, 32'h0);
    nop(0, 1, 1, 16'h0203, 32'h63626160);
    nop(0, 0, 0, 16'h0, 32'h0);
    add(0, 1, 8'h70, 0, 5, 0, 1, 0, 0, 0, 16'h0, 32'h0);
    nop(0, 0, 0, 16'h0, 32'h0);
    nop(0, 0, 0, 16'h0, 32'h0);
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 16'h0, 32'h0);
`ifndef RMW_MERGE_EN
    // lane rewrite: last byte wins, single write
    add(0, 1, 8'h70, 0, 5, 0, 1, 0, 0, 0, 16'h0, 32'h0);
    nop(0, 0, 0, 16'h0, 32'h0);
    add(0, 1, 8'h71, 0, 5, 0, 1, 0, 0, 0, 16'h0, 32'h0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 0, 16'h0280, 32'h00000071);
    nop(0, 0, 0, 16'h0, 32'h0);
    // different-word request evicts the partial word first
    add(0, 1, 8'h11, 4, 1, 0, 1, 0, 0, 0, 16'h0, 32'h0);
    nop(0, 0, 0, 16'h0, 32'h0);
    add(0, 1, 8'h22, 8, 1, 0, 0, 1, 1, 0, 16'h0081, 32'h00000011);
    add(0, 1, 8'h22, 8, 1, 0, 0, 0, 0, 0, 16'h0, 32'h0);
    add(0, 1, 8'h22, 8, 1, 0, 1, 0, 0, 0, 16'h0, 32'h0);
    nop(0, 0, 0, 16'h0, 32'h0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 0, 16'h0082, 32'h00000022);
    nop(0, 0, 0, 16'h0, 32'h0);
    // request held one cycle past its ack
    add(0, 1, 8'h33, 0, 2, 0, 1, 0, 0, 0, 16'h0, 32'h0);
    add(0, 1, 8'h33, 0, 2, 0, 0, 0, 0, 0, 16'h0, 32'h0);
    nop(0, 0, 0, 16'h0, 32'h0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 0, 16'h0100, 32'h00000033);
    nop(0, 0, 0, 16'h0, 32'h0);
    // partial word without merge: missing lanes are zero
    add(0, 1, 8'h55, 5, 1, 0, 1, 0, 0, 0, 16'h0, 32'h0);
    nop(0, 0, 0, 16'h0, 32'h0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 0, 16'h0081, 32'h00005500);
    nop(0, 0, 0, 16'h0, 32'h0);
    // last word of the frame
    add(0, 1, 8'h99, 511, 479, 0, 1, 0, 0, 0, 16'h0, 32'h0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 0, 16'hEFFF, 32'h99000000);
    nop(0, 0, 0, 16'h0, 32'h0);
`else
    // partial word merged with RAM contents
    add(0, 1, 8'h55, 5, 1, 0, 1, 0, 0, 0, 16'h0, 32'h0);
    nop(0, 0, 0, 16'h0, 32'h0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 0, 1, 1, 16'h0081, 32'h0);
    nop(0, 0, 1, 16'h0, 32'h0);
    nop(0, 1, 1, 16'h0081, 32'hDEAD55EF);
    nop(0, 0, 0, 16'h0, 32'h0);
`endif

    foreach (vecs[i]) begin
      reset  = vecs[i].r;
      wr_req = vecs[i].q;
      pixel  = vecs[i].px;
      pix_h  = vecs[i].h;
      pix_v  = vecs[i].v;
      flush  = vecs[i].f;
      @(posedge clk);
      #1;
      g_flags = {wr_done, mem_we, busy, mem_rd};
      e_flags = {vecs[i].e_done, vecs[i].e_we, vecs[i].e_busy, vecs[i].e_rd};
      ok = (g_flags == e_flags);
      if ((vecs[i].e_we || vecs[i].e_rd) && mem_addr != vecs[i].e_addr)
        ok = 1'b0;
      if (vecs[i].e_we && mem_wdata != vecs[i].e_data)
        ok = 1'b0;
      check($sformatf("vec%0d done/we/busy/rd,addr,data", i), ok,
            {12'h0, g_flags, mem_addr, mem_wdata},
            {12'h0, e_flags, vecs[i].e_addr, vecs[i].e_data});
    end
    reset = 1'b0; wr_req = 1'b0; flush = 1'b0;

    // different-word request latency, initiator holding wr_req
    pixel = 8'h01; pix_h = 9'd0; pix_v = 9'd6; wr_req = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!wr_done && n < 10);
    check("first_ack", wr_done, 64'(n), 64'd1);
    wr_req = 1'b0;
    @(posedge clk); #1;
    pixel = 8'h02; pix_h = 9'd4; wr_req = 1'b1;
    n = 0; wes = 0;
    do begin
      @(posedge clk); #1; n++;
      if (mem_we) wes++;
    end while (!wr_done && n < 20);
    wr_req = 1'b0;
`ifdef RMW_MERGE_EN
    check("evict_latency", n == 5, 64'(n), 64'd5);
`else
    check("evict_latency", n == 3, 64'(n), 64'd3);
`endif
    check("evict_writes", wes == 1, 64'(wes), 64'd1);

    // drain last byte with a flush, bounded wait
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n = 0;
    while (!mem_we && n < 10) begin @(posedge clk); #1; n++; end
    w_addr = mem_addr; w_data = mem_wdata;
    check("drain_write", mem_we && w_addr == 16'h0301 && w_data == 32'h00000002,
          {15'h0, mem_we, w_addr, w_data}, {15'h0, 1'b1, 16'h0301, 32'h00000002});
    repeat (3) @(posedge clk);
    #1;
    check("no_back_to_back_we", b2b == 0, 64'(b2b), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
